// File: rtl/gen_pattern_axis.sv
// gen_pattern_axis: AXI-stream test-pattern generator.
// Emits runs of frames (length beats each, frame_num frames per run or
// unlimited) with a programmable idle gap between frames.
// Payload is selected by MODE: "RANGE" (incrementing counter), "CONST"
// (seed value) or "LFSR" (Galois LFSR, only when GEN_PATTERN_AXIS_LFSR_EN
// is defined; otherwise "LFSR" falls back to "RANGE").
module gen_pattern_axis #(
  parameter int unsigned DSIZE = 32,
  parameter string       MODE  = "RANGE",
  parameter int unsigned KSIZE = DSIZE / 8
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             start,
  input  logic             continuous,
  input  logic [15:0]      length,
  input  logic [15:0]      frame_num,
  input  logic [7:0]       gap,
  input  logic [DSIZE-1:0] seed,
  output logic             busy,
  output logic             done,
  output logic [15:0]      frame_cnt,
  output logic [DSIZE-1:0] axis_tdata,
  output logic             axis_tvalid,
  output logic             axis_tlast,
  output logic             axis_tuser,
  output logic [KSIZE-1:0] axis_tkeep,
  input  logic             axis_tready
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam bit MODE_CONST = (MODE == "CONST");

`ifdef GEN_PATTERN_AXIS_LFSR_EN
  localparam bit MODE_LFSR = (MODE == "LFSR");

  // Galois feedback masks for maximal-length polynomials (tap t -> bit t-1).
  function automatic logic [DSIZE-1:0] lfsr_mask();
    logic [63:0] m;
    case (DSIZE)
      8:       m = 64'h00000000000000B8; // x^8+x^6+x^5+x^4+1
      16:      m = 64'h000000000000D008; // x^16+x^15+x^13+x^4+1
      24:      m = 64'h0000000000E10000; // x^24+x^23+x^22+x^17+1
      32:      m = 64'h0000000080200003; // x^32+x^22+x^2+x^1+1
      40:      m = 64'h000000A000140000; // x^40+x^38+x^21+x^19+1
      48:      m = 64'h0000C00000180000; // x^48+x^47+x^21+x^20+1
      56:      m = 64'h00C0000C00000000; // x^56+x^55+x^36+x^35+1
      64:      m = 64'hD800000000000000; // x^64+x^63+x^61+x^60+1
      default: m = 64'h00000000000000B8;
    endcase
    return DSIZE'(m);
  endfunction

  localparam logic [DSIZE-1:0] LFSR_MASK = lfsr_mask();
`endif

  // Value of the first beat of a run.
  function automatic logic [DSIZE-1:0] first_data(input logic [DSIZE-1:0] s);
    logic [DSIZE-1:0] r;
    r = '0;
    if (MODE_CONST) r = s;
`ifdef GEN_PATTERN_AXIS_LFSR_EN
    if (MODE_LFSR) r = (s == '0) ? DSIZE'(1) : s;
`endif
    return r;
  endfunction

  // Value of the beat following a handshake of beat value d.
  function automatic logic [DSIZE-1:0] next_data(input logic [DSIZE-1:0] d,
                                                 input logic [DSIZE-1:0] s);
    logic [DSIZE-1:0] r;
    r = d + DSIZE'(1);
    if (MODE_CONST) r = s;
`ifdef GEN_PATTERN_AXIS_LFSR_EN
    if (MODE_LFSR) r = d[0] ? ((d >> 1) ^ LFSR_MASK) : (d >> 1);
`endif
    return r;
  endfunction

  logic [1:0]       state_q,      state_d;
  logic [15:0]      len_l_q,      len_l_d;
  logic [15:0]      fnum_l_q,     fnum_l_d;
  logic [7:0]       gap_l_q,      gap_l_d;
  logic [DSIZE-1:0] seed_l_q,     seed_l_d;
  logic             cont_run_q,   cont_run_d;
  logic [15:0]      beat_q,       beat_d;
  logic [15:0]      frames_run_q, frames_run_d;
  logic [7:0]       gap_cnt_q,    gap_cnt_d;
  logic [15:0]      frame_cnt_q,  frame_cnt_d;
  logic [DSIZE-1:0] data_q,       data_d;
  logic             tvalid_q,     tvalid_d;
  logic             tlast_q,      tlast_d;
  logic             tuser_q,      tuser_d;

  logic             hs;
  logic             last_beat;
  logic [15:0]      frames_next;

  assign hs          = tvalid_q && axis_tready;
  assign last_beat   = (beat_q == len_l_q - 16'd1);
  assign frames_next = frames_run_q + 16'd1;

  // Next-state and output-register computation for the run/frame sequencer.
  // tlast/tuser/data for the following beat are prepared at each handshake,
  // so SEND->SEND and GAP->SEND only need to raise tvalid.
  always_comb begin
    state_d      = state_q;
    len_l_d      = len_l_q;
    fnum_l_d     = fnum_l_q;
    gap_l_d      = gap_l_q;
    seed_l_d     = seed_l_q;
    cont_run_d   = cont_run_q;
    beat_d       = beat_q;
    frames_run_d = frames_run_q;
    gap_cnt_d    = gap_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    data_d       = data_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    tuser_d      = tuser_q;

    case (state_q)
      S_IDLE: begin
        if ((start || continuous) && (length != 16'd0)) begin
          state_d      = S_SEND;
          len_l_d      = length;
          fnum_l_d     = frame_num;
          gap_l_d      = gap;
          seed_l_d     = seed;
          cont_run_d   = continuous;
          beat_d       = '0;
          frames_run_d = '0;
          data_d       = first_data(seed);
          tvalid_d     = 1'b1;
          tuser_d      = 1'b1;
          tlast_d      = (length == 16'd1);
        end
      end

      S_SEND: begin
        if (hs) begin
          data_d = next_data(data_q, seed_l_q);
          if (last_beat) begin
            frame_cnt_d  = frame_cnt_q + 16'd1;
            frames_run_d = frames_next;
            beat_d       = '0;
            tuser_d      = 1'b1;
            tlast_d      = (len_l_q == 16'd1);
            if ((!continuous && (fnum_l_q != 16'd0) && (frames_next == fnum_l_q)) ||
                (cont_run_q && !continuous)) begin
              state_d  = S_DONE;
              tvalid_d = 1'b0;
              tuser_d  = 1'b0;
              tlast_d  = 1'b0;
            end else if (gap_l_q != 8'd0) begin
              state_d   = S_GAP;
              gap_cnt_d = gap_l_q;
              tvalid_d  = 1'b0;
            end
          end else begin
            beat_d  = beat_q + 16'd1;
            tuser_d = 1'b0;
            tlast_d = ((beat_q + 16'd1) == (len_l_q - 16'd1));
          end
        end
      end

      S_GAP: begin
        if (gap_cnt_q == 8'd1) begin
          state_d  = S_SEND;
          tvalid_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset overriding any pending handshake.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q      <= S_IDLE;
      len_l_q      <= '0;
      fnum_l_q     <= '0;
      gap_l_q      <= '0;
      seed_l_q     <= '0;
      cont_run_q   <= 1'b0;
      beat_q       <= '0;
      frames_run_q <= '0;
      gap_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      data_q       <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tuser_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_l_q      <= len_l_d;
      fnum_l_q     <= fnum_l_d;
      gap_l_q      <= gap_l_d;
      seed_l_q     <= seed_l_d;
      cont_run_q   <= cont_run_d;
      beat_q       <= beat_d;
      frames_run_q <= frames_run_d;
      gap_cnt_q    <= gap_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      data_q       <= data_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tuser_q      <= tuser_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign frame_cnt   = frame_cnt_q;
  assign axis_tdata  = data_q;
  assign axis_tvalid = tvalid_q;
  assign axis_tlast  = tlast_q;
  assign axis_tuser  = tuser_q;
  assign axis_tkeep  = '1;

endmodule

// File: tb/tb_gen_pattern_axis.sv
// Testbench for gen_pattern_axis: three instances (8-bit RANGE, 32-bit CONST,
// 8-bit LFSR) share one stimulus; handshakes are checked against a
// transaction-level reference built from beat index arithmetic.
module tb_gen_pattern_axis;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst, start, continuous, tready;
  logic [15:0] length, frame_num;
  logic [7:0]  gap;
  logic [31:0] seed;

  logic        r_busy, r_done, r_valid, r_last, r_user;
  logic [15:0] r_fcnt;
  logic [7:0]  r_data;
  logic [0:0]  r_keep;
  logic        c_busy, c_done, c_valid, c_last, c_user;
  logic [15:0] c_fcnt;
  logic [31:0] c_data;
  logic [3:0]  c_keep;
  logic        l_busy, l_done, l_valid, l_last, l_user;
  logic [15:0] l_fcnt;
  logic [7:0]  l_data;
  logic [0:0]  l_keep;

  gen_pattern_axis #(.DSIZE(8), .MODE("RANGE")) dut_r (
    .clock(clock), .rst(rst), .start(start), .continuous(continuous),
    .length(length), .frame_num(frame_num), .gap(gap), .seed(seed[7:0]),
    .busy(r_busy), .done(r_done), .frame_cnt(r_fcnt),
    .axis_tdata(r_data), .axis_tvalid(r_valid), .axis_tlast(r_last),
    .axis_tuser(r_user), .axis_tkeep(r_keep), .axis_tready(tready));

  gen_pattern_axis #(.DSIZE(32), .MODE("CONST")) dut_c (
    .clock(clock), .rst(rst), .start(start), .continuous(continuous),
    .length(length), .frame_num(frame_num), .gap(gap), .seed(seed),
    .busy(c_busy), .done(c_done), .frame_cnt(c_fcnt),
    .axis_tdata(c_data), .axis_tvalid(c_valid), .axis_tlast(c_last),
    .axis_tuser(c_user), .axis_tkeep(c_keep), .axis_tready(tready));

  gen_pattern_axis #(.DSIZE(8), .MODE("LFSR")) dut_l (
    .clock(clock), .rst(rst), .start(start), .continuous(continuous),
    .length(length), .frame_num(frame_num), .gap(gap), .seed(seed[7:0]),
    .busy(l_busy), .done(l_done), .frame_cnt(l_fcnt),
    .axis_tdata(l_data), .axis_tvalid(l_valid), .axis_tlast(l_last),
    .axis_tuser(l_user), .axis_tkeep(l_keep), .axis_tready(tready));

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned exp_fcnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Reference LFSR: polynomial x^8+x^6+x^5+x^4+1, one Galois step.
  function automatic logic [7:0] lfsr_ref(input logic [7:0] x);
    return x[0] ? ((x >> 1) ^ 8'hB8) : (x >> 1);
  endfunction

  // One run: rmode 0 = always ready, 1 = random ready, 2 = 1,0,0,1,1 then 1.
  // cont_stop >= 0 starts with continuous and drops it after that many beats.
  task automatic run(input int len, input int fnum, input int gp,
                     input logic [31:0] sd, input int rmode, input int cont_stop);
    int          total, k, low, cyc, bound, pat_i;
    bit          prev_stall, frame_end, cont;
    logic [7:0]  pd, lf;
    logic        pl, pu;
    logic [31:0] pc;
    logic [4:0]  pat;
    bit [255:0]  seen;
    k = 0; low = 0; cyc = 0; pat_i = 0;
    prev_stall = 0; frame_end = 0; seen = '0;
    pd = '0; pl = 0; pu = 0; pc = '0;
    pat = 5'b11001;
    cont  = (cont_stop >= 0);
    total = cont ? ((cont_stop / len) + 1) * len : len * fnum;
    bound = total * 20 + (total / len + 1) * (gp + 2) + 50;
    lf    = (sd[7:0] == 8'd0) ? 8'd1 : sd[7:0];
    length = 16'(len); frame_num = cont ? 16'd0 : 16'(fnum);
    gap = 8'(gp); seed = sd;
    if (cont) continuous = 1'b1; else start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", r_busy, 1);
    while (k < total && cyc < bound) begin
      case (rmode)
        0:       tready = 1'b1;
        1:       tready = ($urandom_range(0, 9) < 7);
        default: begin tready = (pat_i < 5) ? pat[pat_i] : 1'b1; pat_i++; end
      endcase
      if (frame_end && !r_valid) begin
        low++;
      end else begin
        if (frame_end) begin
          chk("gap_len", low, gp);
          frame_end = 0; low = 0;
        end
        chk("tvalid", r_valid, 1);
        if (r_valid) begin
          if (prev_stall) begin
            chk("hold_data", r_data, pd);
            chk("hold_last", r_last, pl);
            chk("hold_user", r_user, pu);
            chk("hold_cdata", c_data, pc);
          end
          if (tready) begin
            chk("r_data", r_data, 64'(k % 256));
            chk("r_last", r_last, (k % len) == len - 1);
            chk("r_user", r_user, (k % len) == 0);
            chk("c_data", c_data, sd);
            chk("keep", {c_keep, l_keep, r_keep}, 6'h3F);
`ifdef GEN_PATTERN_AXIS_LFSR_EN
            chk("l_data", l_data, lf);
            if (k < 255) begin
              chk("lfsr_unique", seen[l_data], 0);
              seen[l_data] = 1'b1;
            end
            lf = lfsr_ref(lf);
`else
            chk("l_data", l_data, 64'(k % 256));
`endif
            k++;
            if (k % len == 0) begin
              exp_fcnt++;
              if (k < total) frame_end = 1;
            end
            if (cont && k == cont_stop) continuous = 1'b0;
            prev_stall = 0;
          end else begin
            prev_stall = 1;
            pd = r_data; pl = r_last; pu = r_user; pc = c_data;
          end
        end
      end
      // Mid-run input changes and start pulses must have no effect.
      length = 16'($urandom_range(0, 9)); frame_num = 16'($urandom_range(0, 4));
      gap = 8'($urandom_range(0, 6)); seed = $urandom;
      start = ($urandom_range(0, 3) == 0);
      tick();
      cyc++;
    end
    chk("run_complete", k, total);
    start = 1'b0;
    chk("done_pulse", r_done, 1);
    chk("done_tvalid", r_valid, 0);
    chk("frame_cnt", r_fcnt, 64'(exp_fcnt % 65536));
    chk("c_frame_cnt", c_fcnt, 64'(exp_fcnt % 65536));
    tick();
    chk("done_end", r_done, 0);
    chk("idle_busy", r_busy, 0);
    chk("idle_tvalid", r_valid, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; continuous = 1'b0; tready = 1'b1;
    length = '0; frame_num = '0; gap = '0; seed = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_tvalid", r_valid, 0);
    chk("rst_tlast", r_last, 0);
    chk("rst_tuser", r_user, 0);
    chk("rst_done", r_done, 0);
    chk("rst_busy", r_busy, 0);
    chk("rst_rdata", r_data, 0);
    chk("rst_cdata", c_data, 0);
    chk("rst_ldata", l_data, 0);
    chk("rst_fcnt", r_fcnt, 0);

    run(4, 2, 0, $urandom, 0, -1);
    run(3, 1, 0, $urandom, 2, -1);
    run(2, 3, 5, $urandom, 0, -1);
    run(8, 0, 0, $urandom, 0, 8 + 3);

    // A request with length 0 is ignored.
    length = 16'd0; frame_num = 16'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("len0_busy", r_busy, 0);
    chk("len0_tvalid", r_valid, 0);
    tick();
    chk("len0_busy2", r_busy, 0);

    // Reset in the middle of a frame.
    length = 16'd6; frame_num = 16'd1; gap = 8'd0; seed = $urandom;
    tready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("pre_rst_data", r_data, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_fcnt = 0;
    chk("mid_rst_tvalid", r_valid, 0);
    chk("mid_rst_busy", r_busy, 0);
    chk("mid_rst_fcnt", r_fcnt, 0);
    chk("mid_rst_data", r_data, 0);

    run(5, 1, 0, $urandom, 1, -1);
    run(200, 2, 1, $urandom, 1, -1);
    run(255, 1, 0, 32'd0, 0, -1);

    for (int i = 0; i < 12; i++)
      run($urandom_range(1, 6), $urandom_range(1, 3), $urandom_range(0, 3),
          $urandom, 1, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
